// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 key schedule for decryption. It emits round keys 10 down to 0, one per
// rk_valid/rk_ready handshake. It can start from the cipher key (forward-expanded first) or from round key 10.
module aes_inv_key_sched #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         key_is_last,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_index,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, FWD, EMIT} state_t;

  state_t       state_q;
  logic [127:0] key_q;
  logic [3:0]   rnd_q;
  logic [3:0]   idx_q;
  logic         valid_q;
  logic         done_q;

  logic [127:0] fwd_d;
  logic [127:0] rev_d;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box computed as the GF(2^8) inverse (x^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // A single SubWord unit serves both directions: w3 when expanding, v3 when reversing.
  always_comb begin
    logic [31:0] w0, w1, w2, w3, v1, v2, v3, sub_in, t, n0, n1, n2, n3;
    logic [3:0]  rc_sel;
    w0     = key_q[127:96];
    w1     = key_q[95:64];
    w2     = key_q[63:32];
    w3     = key_q[31:0];
    v3     = w3 ^ w2;
    v2     = w2 ^ w1;
    v1     = w1 ^ w0;
    sub_in = (state_q == FWD) ? w3 : v3;
    rc_sel = (state_q == FWD) ? rnd_q : idx_q;
    t      = subword({sub_in[23:0], sub_in[31:24]}) ^ {rcon(rc_sel), 24'h0};
    n0     = w0 ^ t;
    n1     = w1 ^ n0;
    n2     = w2 ^ n1;
    n3     = w3 ^ n2;
    fwd_d  = {n0, n1, n2, n3};
    rev_d  = {w0 ^ t, v1, v2, v3};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      rnd_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            key_q <= key_in;
            if (key_is_last) begin
              state_q <= EMIT;
              rnd_q   <= 4'(NR);
              idx_q   <= 4'(NR);
              valid_q <= 1'b1;
            end else begin
              state_q <= FWD;
              rnd_q   <= 4'd1;
            end
          end
        end
        FWD: begin
          key_q <= fwd_d;
          if (rnd_q == 4'(NR)) begin
            state_q <= EMIT;
            idx_q   <= 4'(NR);
            valid_q <= 1'b1;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        EMIT: begin
          if (rk_ready) begin
            if (idx_q == 4'd0) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              key_q <= rev_d;
              idx_q <= idx_q - 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rk_valid = valid_q;
  assign rk_out   = key_q;
  assign rk_index = idx_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched: FIPS-197 and all-zero key streams, stalls, ignored starts,
// and a reset in the middle of a stream.
module tb_aes_inv_key_sched;

  logic         clk;
  logic         rst;
  logic         start;
  logic         key_is_last;
  logic [127:0] key_in;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] rk_out;
  logic [3:0]   rk_index;
  logic         busy;
  logic         done;

  int unsigned  cmp_cnt = 0;
  int unsigned  err_cnt = 0;
  logic [127:0] fips_k [0:10];
  bit           zero_mode;

  aes_inv_key_sched #(.NR(10)) dut (
    .clk(clk), .rst(rst), .start(start), .key_is_last(key_is_last), .key_in(key_in),
    .rk_ready(rk_ready), .rk_valid(rk_valid), .rk_out(rk_out), .rk_index(rk_index),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 128'(rk_valid), 128'd0);
    check({tag, "_out"},   rk_out,         128'd0);
    check({tag, "_index"}, 128'(rk_index), 128'd0);
    check({tag, "_busy"},  128'(busy),     128'd0);
    check({tag, "_done"},  128'(done),     128'd0);
  endtask

  // Drives start, then waits (bounded) for rk_valid; optionally pokes start with junk while busy.
  task automatic launch(input logic [127:0] key, input bit is_last, input bit poke,
                        input int unsigned exp_lat);
    int unsigned n;
    @(negedge clk);
    start       = 1'b1;
    key_is_last = is_last;
    key_in      = key;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_after_start", 128'(busy), 128'd1);
      start       = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      key_is_last = 1'b1;
      key_in      = 128'hdeadbeef_00112233_44556677_8899aabb;
    end while (!rk_valid && n < 30);
    check("latency", 128'(n), 128'(exp_lat));
  endtask

  // Consumes keys 10..0; rk_out/rk_index must match the expected key while stalled as well.
  task automatic consume(input bit random_ready, input bit poke);
    int k;
    int unsigned guard;
    k = 10;
    guard = 0;
    while (k >= 0 && guard < 300) begin
      guard++;
      rk_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      check("emit_valid", 128'(rk_valid), 128'd1);
      check("emit_index", 128'(rk_index), 128'(k));
      if (!zero_mode)
        check("emit_key", rk_out, fips_k[k]);
      else if (k == 10)
        check("zero_key10", rk_out, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
      else if (k == 1)
        check("zero_key1", rk_out, 128'h62636363626363636263636362636363);
      else if (k == 0)
        check("zero_key0", rk_out, 128'h0);
      if (k == 0 && rk_ready) start = 1'b1;
      @(negedge clk);
      if (rk_ready) k--;
    end
    check("stream_complete", 128'(k), 128'hffffffff_ffffffff_ffffffff_ffffffff);
    rk_ready = 1'b0;
    start    = 1'b0;
    check("done_pulse", 128'(done), 128'd1);
    check("valid_drop", 128'(rk_valid), 128'd0);
    check("idle_busy",  128'(busy), 128'd0);
    @(negedge clk);
    check("done_clear", 128'(done), 128'd0);
    check("idle_stays", 128'(busy), 128'd0);
  endtask

  initial begin
    fips_k[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_k[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_k[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_k[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_k[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_k[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_k[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_k[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_k[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_k[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_k[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    zero_mode   = 1'b0;
    rst         = 1'b1;
    start       = 1'b0;
    key_is_last = 1'b0;
    key_in      = '0;
    rk_ready    = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Cipher key, always ready.
    launch(fips_k[0], 1'b0, 1'b0, 11);
    consume(1'b0, 1'b0);

    // Round key 10 loaded directly, random stalls.
    launch(fips_k[10], 1'b1, 1'b0, 1);
    consume(1'b1, 1'b0);

    // Cipher key with start poked during FWD and EMIT.
    launch(fips_k[0], 1'b0, 1'b1, 11);
    consume(1'b1, 1'b1);

    // Reset while round key 5 is presented.
    launch(fips_k[10], 1'b1, 1'b0, 1);
    rk_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_reset_index", 128'(rk_index), 128'd5);
    check("pre_reset_key", rk_out, fips_k[5]);
    rk_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    check_reset_outputs("held_reset");
    rst = 1'b0;
    launch(fips_k[0], 1'b0, 1'b0, 11);
    consume(1'b0, 1'b0);

    // All-zero cipher key.
    zero_mode = 1'b1;
    launch(128'h0, 1'b0, 1'b0, 11);
    consume(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
